// File: rtl/arb_mux_n_pkg.sv
// arb_mux_n_pkg
//   Shared constants for the arb_mux_n slice: the MODE encodings and the
//   default channel width and channel count.
//   No ports; imported by arb_mux_n and rr_arbiter.
package arb_mux_n_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. Grants the first requesting
//   channel found searching upward from ptr, wrapping N-1 -> 0.
//   Ports:
//     req        in   N         request per channel
//     ptr        in   clog2(N)  highest-priority channel this cycle
//     grant      out  N         one-hot grant (zero when nothing requests)
//     grant_idx  out  clog2(N)  index of the granted channel
//     any_grant  out  1         some channel was granted
module rr_arbiter
  import arb_mux_n_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant
);

  localparam int IW = $clog2(N);

  int idx;

  // Walk the offsets from the farthest to the nearest so that the channel
  // closest to ptr (offset 0 first) is the last one written and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n
//   N-channel arbitrating multiplexer with a one-word registered output
//   stage. MODE_SEL picks the channel from S; MODE_RR arbitrates round-robin.
//   Ports:
//     clk        in   1         clock, rising edge
//     rst_n      in   1         asynchronous active-low reset
//     in_data    in   N*WIDTH   channel i at [i*WIDTH +: WIDTH]
//     in_valid   in   N         channel i offers a word
//     in_ready   out  N         channel i word accepted this cycle (one-hot/zero)
//     S          in   clog2(N)  channel select (MODE_SEL only)
//     out_data   out  WIDTH     registered selected word
//     out_valid  out  1         out_data holds a word
//     out_ready  in   1         downstream accepts out_data
//     out_chan   out  clog2(N)  source channel of out_data
module arb_mux_n
  import arb_mux_n_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int MODE  = MODE_RR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [$clog2(N)-1:0] S,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_chan
);

  localparam int IW = $clog2(N);

  logic          can_load;
  logic [IW-1:0] ptr;
  logic [N-1:0]  rr_grant;
  logic [IW-1:0] rr_idx;
  logic          rr_any;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          any_grant;
  logic [WIDTH-1:0] sel_data;

  // The output register may take a new word when empty or when its current
  // word leaves this very cycle.
  assign can_load = !out_valid || out_ready;

  rr_arbiter #(.N(N)) u_rr (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any_grant (rr_any)
  );

  // Comparing S as an integer means an out-of-range S (non power-of-two N)
  // matches no channel and so grants nothing. Grants are forced off while
  // reset is held so in_ready stays zero.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (MODE == MODE_SEL) begin
      for (int i = 0; i < N; i++) begin
        if (int'(S) == i) grant[i] = in_valid[i];
      end
      grant_idx = S;
    end else begin
      grant     = rr_any ? rr_grant : '0;
      grant_idx = rr_idx;
    end
    if (!can_load || !rst_n) grant = '0;
  end

  assign any_grant = |grant;
  assign in_ready  = grant;

  // AND-OR selector: the one-hot grant masks each channel's word.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
      if (any_grant) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= grant_idx;
        ptr       <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, data width in bits per channel (1..64).
REQ-002 The module SHALL have parameter N, default 4, number of input channels (2..16).
REQ-003 The module SHALL have parameter MODE, default 1: 0 = external select via S, 1 = round-robin arbitration.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  channel i offers a word.
REQ-008 in_ready  output  N  channel i word accepted this cycle (one-hot or zero).
REQ-009 S  input  clog2(N)  channel select, used only when MODE=0.
REQ-010 out_data  output  WIDTH  registered selected word.
REQ-011 out_valid  output  1  out_data holds a word.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_chan  output  clog2(N)  source channel of the word in out_data.

Function
REQ-014 An output transfer SHALL occur in a cycle where out_valid=1 and out_ready=1.
REQ-015 The output stage SHALL be able to load in a cycle where out_valid=0, or where an output transfer occurs (no-bubble throughput, 1 word/cycle).
REQ-016 In MODE=0, when the output stage can load, in_ready[S] SHALL equal in_valid[S]; all other in_ready bits SHALL be 0.
REQ-017 In MODE=1, when the output stage can load, grant SHALL go to the first channel with in_valid=1 searching upward from ptr, wrapping N-1 -> 0.
REQ-018 The round-robin pointer ptr SHALL update to (granted index + 1) mod N on every grant, and SHALL hold when no grant occurs.
REQ-019 When the output stage cannot load, in_ready SHALL be all zero regardless of in_valid.
REQ-020 On a grant, out_data, out_chan and out_valid=1 SHALL appear on the next rising edge (latency 1 cycle).
REQ-021 On an output transfer with no grant in the same cycle, out_valid SHALL go to 0 on the next edge.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_chan SHALL hold stable.
REQ-023 in_ready SHALL be combinational from in_valid, S, ptr, out_valid, out_ready; no combinational path from in_data to any output.
REQ-024 If N is not a power of two, in MODE=0 an S value >= N SHALL produce no grant.
REQ-025 In MODE=1, with all N channels continuously valid and out_ready=1, grants SHALL cycle 0,1,...,N-1,0 after reset.

Reset
REQ-026 While rst_n=0: out_valid=0, out_data=0, out_chan=0, ptr=0; in_ready SHALL be 0.
REQ-027 Assertion of rst_n mid-transfer SHALL discard the held word immediately; no grant occurs in the reset-release cycle's preceding edge.
REQ-028 After rst_n deasserts, the first grant SHALL be possible on the first rising edge.

Structure
REQ-029 A shared package SHALL hold the MODE encodings (MODE_SEL=0, MODE_RR=1) and the default WIDTH and N constants.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (parameter N; inputs req, ptr; outputs one-hot grant, grant index, any_grant).
REQ-031 The data path SHALL be a parametrised N:1 AND-OR selector driven by the one-hot grant, feeding the output register.

Verification
REQ-032 MODE=0, N=4, WIDTH=32: S=2, in_data ch2=0xDEADBEEF, all valid, out_ready=1 -> next cycle out_data=0xDEADBEEF, out_chan=2, in_ready=4'b0100.
REQ-033 MODE=1, N=4: all valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
REQ-034 MODE=1: only ch1 and ch3 valid, ptr=2 -> grant ch3, then ch1, then ch3.
REQ-035 Backpressure: out_valid=1, out_ready=0 for 5 cycles -> in_ready=0, out_data stable; out_ready=1 -> transfer and new grant same cycle, no bubble.
REQ-036 Reset mid-stream: rst_n=0 while out_valid=1 -> out_valid=0, out_data=0 asynchronously; after release, MODE=1 grant restarts at ch0.
REQ-037 N=3, MODE=0, S=3 with all valid -> in_ready=0, out_valid stays 0.
